axil_ctrl_regs: RTL
===================

// Module: axil_ctrl_regs
// PURPOSE
//  AXI4-Lite slave register bank hung off the PS master GP port; the role's control/status plane.
//  Converts PS AXI-Lite accesses into a start pulse, a sticky done flag with interrupt, and user registers.
//  Sits between the shell's PS master GP interface and the role; one instance per role.
// PARAMETERS
//  ADDR_WIDTH  12  byte-address width of s_axil_*addr; decode uses addr[ADDR_WIDTH-1:2], addr[1:0] ignored
//  NUM_USER    8   number of 32-bit user RW registers at 0x10 + 4*k, k = 0..NUM_USER-1
// PORTS
//  clk            in   1               single clock, shared by the AXI port and the role side
//  rst            in   1               asynchronous, active-high reset
//  s_axil_awaddr  in   ADDR_WIDTH      write address
//  s_axil_awvalid in   1               write address valid
//  s_axil_awready out  1               write address ready
//  s_axil_wdata   in   32              write data
//  s_axil_wstrb   in   4               write byte strobes
//  s_axil_wvalid  in   1               write data valid
//  s_axil_wready  out  1               write data ready
//  s_axil_bresp   out  2               write response: 2'b00 OKAY, 2'b10 SLVERR
//  s_axil_bvalid  out  1               write response valid
//  s_axil_bready  in   1               write response ready
//  s_axil_araddr  in   ADDR_WIDTH      read address
//  s_axil_arvalid in   1               read address valid
//  s_axil_arready out  1               read address ready
//  s_axil_rdata   out  32              read data
//  s_axil_rresp   out  2               read response: OKAY or SLVERR
//  s_axil_rvalid  out  1               read data valid
//  s_axil_rready  in   1               read data ready
//  ctrl_start     out  1               one-cycle start pulse to the role
//  stat_busy      in   1               role busy level
//  stat_done      in   1               role done pulse, sets sticky DONE
//  irq            out  1               registered level interrupt: DONE & IRQ_EN
//  user_regs      out  32*NUM_USER     user register k on bits [32k+31:32k]
// BEHAVIOUR
//  Register map:
//   0x00 CTRL: write with wstrb[0] and wdata[0]=1 pulses ctrl_start; reads 0.
//   0x04 STATUS: bit0 BUSY (live, RO); bit1 DONE (sticky, W1C).
//   0x08 IRQ_EN: bit0 RW.
//   0x0C: reserved; writes ignored, reads 0, OKAY.
//   0x10 onwards: USER[k], honour wstrb per byte.
//   Address >= 0x10+4*NUM_USER: SLVERR, no state change, rdata=0.
//  Reset values: all outputs 0, including awready/wready/arready. Readies rise on the first clk after rst
//   deasserts. DONE, IRQ_EN and user registers reset to 0.
//  Write FSM (W_IDLE -> W_RESP):
//   - AW and W are accepted independently and latched.
//   - awready drops after its handshake; wready drops after its handshake.
//   - Once both are held: register updates, bvalid=1 and bresp are set on the next clk.
//   - bvalid and bresp are held stable until bready.
//   - awready and wready reassert on the clk after the B handshake. At most one write outstanding.
//  Read FSM (R_IDLE -> R_DATA):
//   - AR handshake drops arready.
//   - rvalid, rdata and rresp are valid the next clk and held stable until rready.
//   - arready reasserts on the clk after the R handshake.
//   - Read latency: 1 clk from AR handshake.
//  Read and write paths are independent. A same-cycle read and write to the same address returns the
//   pre-write value.
//  ctrl_start: high exactly 1 clk, on the clk the write commits. Back-to-back START writes give separate
//   pulses.
//  DONE: stat_done and a DONE W1C in the same clk -> set wins. irq follows DONE & IRQ_EN with 1 clk latency.
//  rst asserted mid-transaction: all valid/ready signals drop immediately and latched AW/W are discarded.
//   No response is issued for a transaction cut off by reset.
// STRUCTURE
//  Package axil_regs_pkg holds the register offsets (REG_CTRL, REG_STATUS, REG_IRQ_EN, REG_USER0),
//   the resp_t enum (OKAY/SLVERR), DATA_W=32 and the state enums.
//  Single module, no sub-modules; the write and read FSMs are separate always_ff blocks.
// TESTING
//  1. Write 0x10=0xDEADBEEF with wstrb=4'hF, then read 0x10 -> bresp=OKAY, rdata=0xDEADBEEF,
//     user_regs[31:0]=0xDEADBEEF.
//  2. W issued 3 clk before AW, bready held low 5 clk -> exactly one B, bvalid held stable,
//     awready/wready low until the B handshake.
//  3. Write CTRL=0x1 twice back-to-back -> two 1-clk ctrl_start pulses; read CTRL -> 0x0.
//  4. IRQ_EN=1 then a stat_done pulse -> STATUS=0x2, irq=1 next clk. W1C 0x04=0x2 in the same clk as
//     stat_done -> DONE stays 1. W1C alone -> irq=0 one clk later.
//  5. Read/write 0x10+4*NUM_USER -> SLVERR, rdata=0, no register changes. Write 0x14=0xFFFFFFFF with
//     wstrb=4'h3 over 0x11223344 -> 0x1122FFFF.
//  6. Assert rst while rvalid=1 and while AW is latched -> rvalid/bvalid go 0 asynchronously; after
//     release, a clean write/read completes.

Source files
------------

// File: rtl/axil_regs_pkg.sv
// Shared definitions for the AXI4-Lite control/status register bank:
// register offsets, response codes, FSM states and the byte-strobe merge helper.
package axil_regs_pkg;

    localparam int DATA_W = 32;

    localparam logic [31:0] REG_CTRL   = 32'h0000_0000;
    localparam logic [31:0] REG_STATUS = 32'h0000_0004;
    localparam logic [31:0] REG_IRQ_EN = 32'h0000_0008;
    localparam logic [31:0] REG_RSVD   = 32'h0000_000C;
    localparam logic [31:0] REG_USER0  = 32'h0000_0010;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wstate_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    typedef enum logic [2:0] {
        SEL_CTRL   = 3'd0,
        SEL_STATUS = 3'd1,
        SEL_IRQ_EN = 3'd2,
        SEL_RSVD   = 3'd3,
        SEL_USER   = 3'd4,
        SEL_ERR    = 3'd5
    } sel_t;

    function automatic logic [DATA_W-1:0] strb_merge(
        input logic [DATA_W-1:0]   old_val,
        input logic [DATA_W-1:0]   new_val,
        input logic [DATA_W/8-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int b = 0; b < DATA_W/8; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_val[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axil_ctrl_regs.sv
// AXI4-Lite slave register bank: start pulse, sticky done with interrupt and user registers.
// Independent single-outstanding write and read channels.
module axil_ctrl_regs
    import axil_regs_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_USER   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_WIDTH-1:0]      s_axil_awaddr,
    input  logic                       s_axil_awvalid,
    output logic                       s_axil_awready,
    input  logic [31:0]                s_axil_wdata,
    input  logic [3:0]                 s_axil_wstrb,
    input  logic                       s_axil_wvalid,
    output logic                       s_axil_wready,
    output logic [1:0]                 s_axil_bresp,
    output logic                       s_axil_bvalid,
    input  logic                       s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]      s_axil_araddr,
    input  logic                       s_axil_arvalid,
    output logic                       s_axil_arready,
    output logic [31:0]                s_axil_rdata,
    output logic [1:0]                 s_axil_rresp,
    output logic                       s_axil_rvalid,
    input  logic                       s_axil_rready,
    output logic                       ctrl_start,
    input  logic                       stat_busy,
    input  logic                       stat_done,
    output logic                       irq,
    output logic [32*NUM_USER-1:0]     user_regs
);

    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [ADDR_WIDTH-1:0] USER_BASE = REG_USER0[ADDR_WIDTH-1:0];
    localparam logic [ADDR_WIDTH:0]   USER_END  = (ADDR_WIDTH+1)'(REG_USER0 + 32'(4*NUM_USER));

    function automatic sel_t decode(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] al;
        al = a & WORD_MASK;
        if (al == REG_CTRL[ADDR_WIDTH-1:0]) begin
            return SEL_CTRL;
        end else if (al == REG_STATUS[ADDR_WIDTH-1:0]) begin
            return SEL_STATUS;
        end else if (al == REG_IRQ_EN[ADDR_WIDTH-1:0]) begin
            return SEL_IRQ_EN;
        end else if (al == REG_RSVD[ADDR_WIDTH-1:0]) begin
            return SEL_RSVD;
        end else if (({1'b0, al} >= {1'b0, USER_BASE}) && ({1'b0, al} < USER_END)) begin
            return SEL_USER;
        end else begin
            return SEL_ERR;
        end
    endfunction

    // Index only meaningful when decode() returned SEL_USER.
    function automatic logic [ADDR_WIDTH-1:0] user_idx(input logic [ADDR_WIDTH-1:0] a);
        return (a - USER_BASE) >> 2;
    endfunction

    wstate_t                 wstate_r;
    rstate_t                 rstate_r;
    logic                    awready_r, wready_r, bvalid_r;
    logic                    arready_r, rvalid_r;
    resp_t                   bresp_r, rresp_r;
    logic [DATA_W-1:0]       rdata_r;
    logic                    aw_held_r, w_held_r;
    logic [ADDR_WIDTH-1:0]   aw_addr_r;
    logic [DATA_W-1:0]       w_data_r;
    logic [3:0]              w_strb_r;
    logic                    done_r, irq_en_r, irq_r, ctrl_start_r;
    logic [DATA_W-1:0]       user_r [NUM_USER];

    logic                    aw_hs_s, w_hs_s, ar_hs_s, commit_s;
    logic [ADDR_WIDTH-1:0]   wr_addr_s;
    logic [DATA_W-1:0]       wr_data_s;
    logic [3:0]              wr_strb_s;
    sel_t                    wsel_s, rsel_s;
    logic [ADDR_WIDTH-1:0]   widx_s, ridx_s;
    logic [DATA_W-1:0]       rd_word_s;

    // Write-side handshakes and the effective (latched or live) write beat.
    always_comb begin
        aw_hs_s   = s_axil_awvalid & awready_r;
        w_hs_s    = s_axil_wvalid & wready_r;
        wr_addr_s = aw_held_r ? aw_addr_r : s_axil_awaddr;
        wr_data_s = w_held_r ? w_data_r : s_axil_wdata;
        wr_strb_s = w_held_r ? w_strb_r : s_axil_wstrb;
        commit_s  = (wstate_r == W_IDLE) & (aw_held_r | aw_hs_s) & (w_held_r | w_hs_s);
        wsel_s    = decode(wr_addr_s);
        widx_s    = user_idx(wr_addr_s);
    end

    // Write channel FSM: latch AW and W independently, commit when both present, hold B until bready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate_r  <= W_IDLE;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            aw_addr_r <= '0;
            w_data_r  <= '0;
            w_strb_r  <= 4'h0;
        end else begin
            case (wstate_r)
                W_IDLE: begin
                    if (aw_hs_s) begin
                        aw_held_r <= 1'b1;
                        aw_addr_r <= s_axil_awaddr;
                    end
                    if (w_hs_s) begin
                        w_held_r <= 1'b1;
                        w_data_r <= s_axil_wdata;
                        w_strb_r <= s_axil_wstrb;
                    end
                    if (commit_s) begin
                        aw_held_r <= 1'b0;
                        w_held_r  <= 1'b0;
                        awready_r <= 1'b0;
                        wready_r  <= 1'b0;
                        bvalid_r  <= 1'b1;
                        bresp_r   <= (wsel_s == SEL_ERR) ? RESP_SLVERR : RESP_OKAY;
                        wstate_r  <= W_RESP;
                    end else begin
                        awready_r <= ~(aw_held_r | aw_hs_s);
                        wready_r  <= ~(w_held_r | w_hs_s);
                    end
                end
                W_RESP: begin
                    if (s_axil_bready) begin
                        bvalid_r  <= 1'b0;
                        bresp_r   <= RESP_OKAY;
                        awready_r <= 1'b1;
                        wready_r  <= 1'b1;
                        wstate_r  <= W_IDLE;
                    end
                end
                default: begin
                    wstate_r <= W_IDLE;
                end
            endcase
        end
    end

    // Register state: start pulse, sticky done (set beats W1C), irq enable, user registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_start_r <= 1'b0;
            done_r       <= 1'b0;
            irq_en_r     <= 1'b0;
            irq_r        <= 1'b0;
            for (int k = 0; k < NUM_USER; k++) begin
                user_r[k] <= '0;
            end
        end else begin
            ctrl_start_r <= commit_s & (wsel_s == SEL_CTRL) & wr_strb_s[0] & wr_data_s[0];
            done_r       <= stat_done |
                            (done_r & ~(commit_s & (wsel_s == SEL_STATUS) & wr_strb_s[0] & wr_data_s[1]));
            irq_r        <= done_r & irq_en_r;
            if (commit_s && (wsel_s == SEL_IRQ_EN) && wr_strb_s[0]) begin
                irq_en_r <= wr_data_s[0];
            end
            for (int k = 0; k < NUM_USER; k++) begin
                if (commit_s && (wsel_s == SEL_USER) && (widx_s == ADDR_WIDTH'(k))) begin
                    user_r[k] <= strb_merge(user_r[k], wr_data_s, wr_strb_s);
                end
            end
        end
    end

    // Read data mux, sampled at the AR handshake so a same-cycle write is not visible.
    always_comb begin
        ar_hs_s   = s_axil_arvalid & arready_r;
        rsel_s    = decode(s_axil_araddr);
        ridx_s    = user_idx(s_axil_araddr);
        rd_word_s = '0;
        case (rsel_s)
            SEL_STATUS: rd_word_s = {{(DATA_W-2){1'b0}}, done_r, stat_busy};
            SEL_IRQ_EN: rd_word_s = {{(DATA_W-1){1'b0}}, irq_en_r};
            SEL_USER: begin
                for (int k = 0; k < NUM_USER; k++) begin
                    if (ridx_s == ADDR_WIDTH'(k)) begin
                        rd_word_s = user_r[k];
                    end else begin
                        rd_word_s = rd_word_s;
                    end
                end
            end
            default: rd_word_s = '0;
        endcase
    end

    // Read channel FSM: one-cycle latency, R held until rready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate_r  <= R_IDLE;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= '0;
            rresp_r   <= RESP_OKAY;
        end else begin
            case (rstate_r)
                R_IDLE: begin
                    if (ar_hs_s) begin
                        arready_r <= 1'b0;
                        rvalid_r  <= 1'b1;
                        rdata_r   <= rd_word_s;
                        rresp_r   <= (rsel_s == SEL_ERR) ? RESP_SLVERR : RESP_OKAY;
                        rstate_r  <= R_DATA;
                    end else begin
                        arready_r <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axil_rready) begin
                        rvalid_r  <= 1'b0;
                        rdata_r   <= '0;
                        rresp_r   <= RESP_OKAY;
                        arready_r <= 1'b1;
                        rstate_r  <= R_IDLE;
                    end
                end
                default: begin
                    rstate_r <= R_IDLE;
                end
            endcase
        end
    end

    assign s_axil_awready = awready_r;
    assign s_axil_wready  = wready_r;
    assign s_axil_bvalid  = bvalid_r;
    assign s_axil_bresp   = bresp_r;
    assign s_axil_arready = arready_r;
    assign s_axil_rvalid  = rvalid_r;
    assign s_axil_rdata   = rdata_r;
    assign s_axil_rresp   = rresp_r;
    assign ctrl_start     = ctrl_start_r;
    assign irq            = irq_r;

    for (genvar g = 0; g < NUM_USER; g++) begin : g_user_out
        assign user_regs[32*g +: 32] = user_r[g];
    end

endmodule
